// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the burst reader: cycle-type codes and FSM states.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_BURST,
    S_GAP
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head word is always on rd_data
// while not empty. Pops on an empty FIFO are ignored; the writer must not push
// while full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage write port.
  // NOTE: the data array has no reset; only pointers and count are cleared, so
  // it can map onto RAM and the head word is don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone pipelined burst master: reads len_i words starting at base_adr_i in
// incrementing bursts of up to BURST_LEN beats, buffering them in a FIFO that is
// drained through a valid/ready stream. A burst starts only when the FIFO can
// take all of it, so the slave never sees back-pressure mid-burst.
module wb_burst_reader
  import wb_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [31:0] base_adr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [15:0]   rem_q, rem_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [BW-1:0] blen_q, blen_d;
  logic [BW-1:0] blen_w;
  logic          cyc_q, cyc_d;
  logic [2:0]    cti_q, cti_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last_beat;
  logic          room_ok;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Size of the next burst and whether the FIFO can absorb all of it.
  assign blen_w    = (rem_q >= 16'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(rem_q);
  assign room_ok   = (32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(blen_w);
  assign last_beat = (beat_q == blen_q - BW'(1));

  // Next-state and next-output logic; every Wishbone output is registered.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    blen_d    = blen_q;
    cyc_d     = cyc_q;
    cti_d     = cti_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == 16'd0) begin
            done_d = 1'b1;
          end else begin
            adr_d   = base_adr_i & ~32'd3;
            rem_d   = len_i;
            busy_d  = 1'b1;
            state_d = S_WAIT_SPACE;
          end
        end
      end
      S_WAIT_SPACE: begin
        beat_d = '0;
        if (room_ok) begin
          blen_d  = blen_w;
          cyc_d   = 1'b1;
          cti_d   = (blen_w == BW'(1)) ? CTI_CLASSIC : CTI_INCR;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (wb_ack_i) begin
          fifo_push = !fifo_full;
          adr_d     = adr_q + 32'd4;
          beat_d    = beat_q + BW'(1);
          rem_d     = rem_q - 16'd1;
          if (last_beat) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = S_GAP;
          end else if (beat_q + BW'(1) == blen_q - BW'(1)) begin
            cti_d = CTI_EOB;
          end else begin
            cti_d = CTI_INCR;
          end
        end
      end
      S_GAP: begin
        // One idle cycle with cyc low lets the slave restart its burst counter.
        if (rem_q != 16'd0) begin
          state_d = S_WAIT_SPACE;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered-output update.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      blen_q  <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      blen_q  <= blen_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wb_adr_o   = adr_q;
  assign wb_cti_o   = cti_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_sel_o   = 4'hF;
  assign wb_we_o    = 1'b0;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rd_valid_o = !fifo_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .push    (fifo_push),
    .wr_data (wb_dat_i),
    .pop     (rd_ready_i),
    .rd_data (rd_data_o),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: a Wishbone slave model with optional
// wait states, a scoreboard of expected addresses, cycle types and stream data,
// and one task per scenario.
module tb_wb_burst_reader;
  import wb_pkg::*;

  localparam int BURST_LEN  = 8;
  localparam int FIFO_DEPTH = 32;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_adr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;

  wb_burst_reader #(
    .BURST_LEN  (BURST_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .start_i    (start_i),
    .base_adr_i (base_adr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel_o),
    .wb_cti_o   (wb_cti_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_data[$];
  logic [31:0] exp_adr[$];
  logic [2:0]  exp_cti[$];
  int          burst_sizes[$];
  int          gaps[$];
  int          n_acks = 0;
  int          done_cnt = 0;
  int          overflow_cnt = 0;
  int          max_wait = 0;
  int          wait_left = 0;

  localparam logic [44:0] RESET_VEC = {6'b0, 3'b000, 4'hF, 32'h0};

  // Memory contents seen by the slave: a fixed function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h0123};
  endfunction

  // Slave model: acks after 0..max_wait idle cycles, data from mem_word.
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 32'hDEAD_BEEF;
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (!wb_rst_ni || !(wb_cyc_o && wb_stb_o)) begin
        wb_ack_i = 1'b0;
        if (!wb_rst_ni) wait_left = 0;
      end else if (wait_left == 0) begin
        wb_ack_i  = 1'b1;
        wb_dat_i  = mem_word(wb_adr_o);
        wait_left = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
      end else begin
        wb_ack_i  = 1'b0;
        wb_dat_i  = 32'hDEAD_BEEF;
        wait_left = wait_left - 1;
      end
    end
  end

  // Bus and stream monitor: scoreboard compares, hold checks, burst statistics.
  logic        prev_cyc = 1'b0;
  int          beats = 0;
  int          gap_cnt = 0;
  logic        held_valid = 1'b0;
  logic [31:0] held_adr;
  logic        held_dvalid = 1'b0;
  logic [31:0] held_data;

  always @(negedge wb_clk_i) begin
    logic [31:0] ea, ed;
    logic [2:0]  ec;
    if (!wb_rst_ni) begin
      beats       = 0;
      gap_cnt     = 0;
      prev_cyc    = 1'b0;
      held_valid  = 1'b0;
      held_dvalid = 1'b0;
    end else begin
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        n_acks = n_acks + 1;
        beats  = beats + 1;
        if (dut.fifo_full) overflow_cnt = overflow_cnt + 1;
        n_checks = n_checks + 1;
        if (exp_adr.size() == 0) begin
          n_errors = n_errors + 1;
          $display("FAIL wb_beat: unexpected ack at adr %h", wb_adr_o);
        end else begin
          ea = exp_adr.pop_front();
          ec = exp_cti.pop_front();
          if (wb_adr_o !== ea) begin
            n_errors = n_errors + 1;
            $display("FAIL wb_adr: got %h expected %h", wb_adr_o, ea);
          end
          n_checks = n_checks + 1;
          if (wb_cti_o !== ec) begin
            n_errors = n_errors + 1;
            $display("FAIL wb_cti at %h: got %b expected %b", wb_adr_o, wb_cti_o, ec);
          end
        end
      end
      if (held_valid && wb_cyc_o) begin
        n_checks = n_checks + 1;
        if (wb_adr_o !== held_adr) begin
          n_errors = n_errors + 1;
          $display("FAIL adr_hold: adr moved to %h without ack, held %h", wb_adr_o, held_adr);
        end
      end
      held_valid = wb_cyc_o && wb_stb_o && !wb_ack_i;
      held_adr   = wb_adr_o;
      if (prev_cyc && !wb_cyc_o) begin
        burst_sizes.push_back(beats);
        beats = 0;
      end
      if (!prev_cyc && wb_cyc_o) begin
        gaps.push_back(gap_cnt);
        gap_cnt = 0;
      end
      if (!wb_cyc_o) gap_cnt = gap_cnt + 1;
      prev_cyc = wb_cyc_o;
      if (done_o) done_cnt = done_cnt + 1;

      if (held_dvalid && rd_valid_o) begin
        n_checks = n_checks + 1;
        if (rd_data_o !== held_data) begin
          n_errors = n_errors + 1;
          $display("FAIL stream_hold: data changed to %h while stalled, held %h", rd_data_o, held_data);
        end
      end
      if (rd_valid_o && rd_ready_i) begin
        n_checks = n_checks + 1;
        if (exp_data.size() == 0) begin
          n_errors = n_errors + 1;
          $display("FAIL stream_data: unexpected word %h", rd_data_o);
        end else begin
          ed = exp_data.pop_front();
          if (rd_data_o !== ed) begin
            n_errors = n_errors + 1;
            $display("FAIL stream_data: got %h expected %h", rd_data_o, ed);
          end
        end
      end
      held_dvalid = rd_valid_o && !rd_ready_i;
      held_data   = rd_data_o;
    end
  end

  // Expected beats of a transfer, split into bursts the way the master must.
  task automatic push_expect(input logic [31:0] base, input int len);
    logic [31:0] a;
    int          rem;
    int          b;
    a   = base & ~32'd3;
    rem = len;
    while (rem > 0) begin
      b = (rem > BURST_LEN) ? BURST_LEN : rem;
      for (int i = 0; i < b; i++) begin
        exp_adr.push_back(a);
        exp_data.push_back(mem_word(a));
        exp_cti.push_back((b == 1) ? CTI_CLASSIC : ((i < b - 1) ? CTI_INCR : CTI_EOB));
        a = a + 32'd4;
      end
      rem = rem - b;
    end
  endtask

  // Pulse start for one cycle; returns 1 time unit after the sampling edge.
  task automatic do_start(input logic [31:0] base, input int len, input bit expect_it);
    @(posedge wb_clk_i);
    #1;
    start_i    = 1'b1;
    base_adr_i = base;
    len_i      = 16'(len);
    if (expect_it) push_expect(base, len);
    @(posedge wb_clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge wb_clk_i);
      #2;
      k++;
    end
    n_checks++;
    if (done_cnt == d0) begin
      n_errors++;
      $display("FAIL %s_done: no done_o within %0d cycles", name, budget);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while ((rd_valid_o || exp_data.size() != 0) && k < budget) begin
      @(posedge wb_clk_i);
      #2;
      k++;
    end
    n_checks++;
    if (exp_data.size() != 0 || exp_adr.size() != 0 || rd_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d words and %0d beats still expected, rd_valid=%b",
               name, exp_data.size(), exp_adr.size(), rd_valid_o);
    end
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #2;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, rd_valid_o, wb_cti_o, wb_sel_o, wb_adr_o} !== RESET_VEC) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected %h",
               {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, rd_valid_o, wb_cti_o, wb_sel_o, wb_adr_o}, RESET_VEC);
    end
    wb_rst_ni = 1'b1;
    repeat (2) @(posedge wb_clk_i);
  endtask

  task automatic test_multi_burst();
    int d0;
    rd_ready_i = 1'b1;
    max_wait   = 0;
    burst_sizes.delete();
    gaps.delete();
    d0 = done_cnt;
    do_start(32'h100, 20, 1'b1);
    wait_done(d0, 200, "multi");
    repeat (5) @(posedge wb_clk_i);
    #2;
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_errors++;
      $display("FAIL multi_done_count: got %0d pulses expected 1", done_cnt - d0);
    end
    n_checks++;
    if (burst_sizes.size() != 3 || burst_sizes[0] != 8 || burst_sizes[1] != 8 || burst_sizes[2] != 4) begin
      n_errors++;
      $display("FAIL multi_bursts: got %0d bursts, sizes %p expected 8/8/4", burst_sizes.size(), burst_sizes);
    end
    n_checks++;
    if (gaps.size() != 3 || gaps[1] < 1 || gaps[2] < 1) begin
      n_errors++;
      $display("FAIL multi_gaps: gaps %p expected at least one idle cycle between bursts", gaps);
    end
    drain(50, "multi");
  endtask

  task automatic test_single_and_empty();
    int d0;
    burst_sizes.delete();
    d0 = done_cnt;
    do_start(32'h102, 1, 1'b1);
    n_checks++;
    if (wb_cyc_o !== 1'b0 || busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL single_wait: cyc=%b busy=%b expected cyc=0 busy=1", wb_cyc_o, busy_o);
    end
    @(posedge wb_clk_i);
    #1;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_adr_o} !== {3'b110, 4'hF, CTI_CLASSIC, 32'h100}) begin
      n_errors++;
      $display("FAIL single_beat: cyc=%b stb=%b we=%b sel=%h cti=%b adr=%h expected 1 1 0 f 000 00000100",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_adr_o);
    end
    wait_done(d0, 50, "single");
    n_checks++;
    if (burst_sizes.size() != 1 || burst_sizes[0] != 1) begin
      n_errors++;
      $display("FAIL single_bursts: sizes %p expected one burst of 1", burst_sizes);
    end
    drain(20, "single");

    d0 = done_cnt;
    do_start(32'h300, 0, 1'b0);
    n_checks++;
    if (done_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_done: done=%b cyc=%b expected done=1 cyc=0", done_o, wb_cyc_o);
    end
    @(posedge wb_clk_i);
    #1;
    n_checks++;
    if (done_o !== 1'b0 || wb_cyc_o !== 1'b0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_after: done=%b cyc=%b busy=%b expected 0 0 0", done_o, wb_cyc_o, busy_o);
    end
  endtask

  task automatic test_back_pressure();
    int d0, a0;
    rd_ready_i = 1'b0;
    d0 = done_cnt;
    a0 = n_acks;
    do_start(32'h1000, 64, 1'b1);
    repeat (150) @(posedge wb_clk_i);
    #2;
    n_checks++;
    if (n_acks - a0 != FIFO_DEPTH || wb_cyc_o !== 1'b0 || busy_o !== 1'b1 || rd_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_stall: acks=%0d cyc=%b busy=%b valid=%b expected 32 0 1 1",
               n_acks - a0, wb_cyc_o, busy_o, rd_valid_o);
    end
    @(posedge wb_clk_i);
    #1;
    rd_ready_i = 1'b1;
    wait_done(d0, 500, "bp");
    drain(50, "bp");
    n_checks++;
    if (n_acks - a0 != 64 || overflow_cnt != 0) begin
      n_errors++;
      $display("FAIL bp_total: acks=%0d overflows=%0d expected 64 and 0", n_acks - a0, overflow_cnt);
    end
  endtask

  task automatic test_wait_states();
    int d0;
    rd_ready_i = 1'b1;
    max_wait   = 5;
    d0 = done_cnt;
    do_start(32'h2000, 40, 1'b1);
    repeat (30) @(posedge wb_clk_i);
    #2;
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL ws_busy: busy=%b expected 1 before mid-transfer start", busy_o);
    end
    do_start(32'h9000, 8, 1'b0);
    wait_done(d0, 2000, "ws");
    repeat (10) @(posedge wb_clk_i);
    #2;
    n_checks++;
    if (done_cnt - d0 != 1 || busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
      n_errors++;
      $display("FAIL ws_end: done pulses=%0d busy=%b cyc=%b expected 1 0 0", done_cnt - d0, busy_o, wb_cyc_o);
    end
    drain(50, "ws");
    max_wait = 0;
  endtask

  task automatic test_wrap();
    int d0;
    burst_sizes.delete();
    d0 = done_cnt;
    do_start(32'hFFFF_FFF8, 4, 1'b1);
    wait_done(d0, 50, "wrap");
    n_checks++;
    if (burst_sizes.size() != 1 || burst_sizes[0] != 4 || wb_adr_o !== 32'h8) begin
      n_errors++;
      $display("FAIL wrap_burst: sizes %p final adr %h expected one burst of 4, adr 00000008",
               burst_sizes, wb_adr_o);
    end
    drain(20, "wrap");
  endtask

  task automatic test_reset_mid();
    int d0, a0, k;
    a0 = n_acks;
    do_start(32'h200, 16, 1'b1);
    k = 0;
    while (n_acks - a0 < 2 && k < 50) begin
      @(posedge wb_clk_i);
      #2;
      k++;
    end
    n_checks++;
    if (n_acks - a0 < 2 || wb_cyc_o !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_setup: acks=%0d cyc=%b expected 2 acks and cyc=1", n_acks - a0, wb_cyc_o);
    end
    wb_rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, rd_valid_o, wb_cti_o, wb_sel_o, wb_adr_o} !== RESET_VEC) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got %h expected %h",
               {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, rd_valid_o, wb_cti_o, wb_sel_o, wb_adr_o}, RESET_VEC);
    end
    exp_data.delete();
    exp_adr.delete();
    exp_cti.delete();
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1;
    d0 = done_cnt;
    do_start(32'h400, 6, 1'b1);
    wait_done(d0, 100, "rst_restart");
    drain(20, "rst_restart");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multi_burst();
    test_single_and_empty();
    test_back_pressure();
    test_wait_states();
    test_wrap();
    test_reset_mid();
    repeat (5) @(posedge wb_clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
